// File: rtl/lut_config_loader.sv
// lut_config_loader: assembles streamed config words into LUT images and writes each image with a one-hot cen pulse.
// Define LUT_CFG_CHECKSUM_EN to add a trailing XOR checksum word and the error output.
module lut_config_loader #(
  parameter int INPUTS       = 4,
  parameter int MEM_SIZE     = 2**INPUTS,
  parameter int CONFIG_WIDTH = 4,
  parameter int NUM_LUTS     = 8
) (
  input  logic                    cclk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CONFIG_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [MEM_SIZE-1:0]     config_out,
  output logic [NUM_LUTS-1:0]     cen,
  output logic                    busy,
  output logic                    done
`ifdef LUT_CFG_CHECKSUM_EN
  ,
  output logic                    error
`endif
);
  localparam int WPL = MEM_SIZE / CONFIG_WIDTH;
  localparam int WW  = WPL > 1 ? $clog2(WPL) : 1;
  localparam int LW  = NUM_LUTS > 1 ? $clog2(NUM_LUTS) : 1;
`ifdef LUT_CFG_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
  localparam state_t FIN = CHECK;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
  localparam state_t FIN = DONE;
`endif
  state_t              state_q, state_d;
  logic [WW-1:0]       word_q, word_d;
  logic [LW-1:0]       lut_q, lut_d;
  logic [MEM_SIZE-1:0] cfg_q, cfg_d;
  logic                accept, last_word, last_lut;
`ifdef LUT_CFG_CHECKSUM_EN
  logic [CONFIG_WIDTH-1:0] xor_q, xor_d;
  logic                    err_q, err_d;
  assign in_ready = state_q == LOAD || state_q == CHECK;
  assign error    = err_q;
`else
  assign in_ready = state_q == LOAD;
`endif
  assign accept     = in_valid && in_ready;
  assign last_word  = word_q == WW'(WPL-1);
  assign last_lut   = lut_q == LW'(NUM_LUTS-1);
  assign config_out = cfg_q;
  assign cen        = state_q == WRITE ? NUM_LUTS'(1) << lut_q : '0;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    lut_d   = lut_q;
    cfg_d   = cfg_q;
`ifdef LUT_CFG_CHECKSUM_EN
    xor_d   = xor_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        word_d  = '0;
        lut_d   = '0;
`ifdef LUT_CFG_CHECKSUM_EN
        xor_d   = '0;
        err_d   = 1'b0;
`endif
      end
      LOAD: if (accept) begin
        cfg_d[int'(word_q)*CONFIG_WIDTH +: CONFIG_WIDTH] = in_data;
        word_d  = last_word ? '0 : word_q + 1'b1;
        state_d = last_word ? WRITE : LOAD;
`ifdef LUT_CFG_CHECKSUM_EN
        xor_d   = xor_q ^ in_data;
`endif
      end
      WRITE: begin
        state_d = last_lut ? FIN : LOAD;
        lut_d   = last_lut ? lut_q : lut_q + 1'b1;
      end
`ifdef LUT_CFG_CHECKSUM_EN
      CHECK: if (accept) begin
        err_d   = in_data != xor_q;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      lut_q   <= '0;
      cfg_q   <= '0;
`ifdef LUT_CFG_CHECKSUM_EN
      xor_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      lut_q   <= lut_d;
      cfg_q   <= cfg_d;
`ifdef LUT_CFG_CHECKSUM_EN
      xor_q   <= xor_d;
      err_q   <= err_d;
`endif
    end
  end
endmodule
